// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-path types and constants for the PC fetch unit.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        VALID
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = ~32'h0000_0003;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register plus instruction fetch over a req/gnt/rvalid handshake.
// Optional `PC_ALIGN_CHECK_EN forces word-aligned PC loads and raises sticky pc_misalign.
module pc_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [31:0]      next_pc,
    input  logic             pc_load,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      PC,
    output logic [31:0]      instruction,
    output logic             instr_valid,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic             pc_misalign
);

    localparam int unsigned        TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0]   TMR_MAX  = TMR_W'(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q;
    logic [TMR_W-1:0] timer_q;

    logic capture, timeout, commit, tmr_clr, tmr_inc;

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // rvalid only matters in WAIT; a response arriving with gnt or after a timeout is dropped.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        timeout = 1'b0;
        commit  = 1'b0;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                    tmr_clr = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    capture = 1'b1;
                    state_d = VALID;
                end else if (timer_q >= TMR_LAST) begin
                    timeout = 1'b1;
                    state_d = REQ;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            VALID: begin
                if (pc_load) begin
                    commit  = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            instruction <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_cnt   <= '0;
            timer_q     <= '0;
        end else begin
            fetch_err <= timeout;
            if (tmr_clr)
                timer_q <= '0;
            else if (tmr_inc && timer_q != TMR_MAX)
                timer_q <= timer_q + TMR_W'(1);
            if (capture) begin
                instruction <= imem_rdata;
                instr_valid <= 1'b1;
                fetch_cnt   <= fetch_cnt + CNT_W'(1);
            end
            if (commit) begin
                instr_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                pc_q <= next_pc & WORD_ALIGN_MASK;
`else
                pc_q <= next_pc;
`endif
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset)
            misalign_q <= 1'b0;
        else if (commit && next_pc[1:0] != 2'b00)
            misalign_q <= 1'b1;
    end

    assign pc_misalign = misalign_q;
`else
    assign pc_misalign = 1'b0;
`endif

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;
    assign PC        = pc_q;

endmodule
